// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: fetches the word at pc, splits it into opcode/operand,
// issues it to the datapath and tracks CALL/RET nesting against the return-stack size.
module fetch_sequencer #(
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = 16,
    parameter int OPCODE_WIDTH = 4,
    parameter int VALUE_WIDTH  = 12,
    parameter int STACK_DEPTH  = 16,
    parameter logic [OPCODE_WIDTH-1:0] OP_CALL  = 4'h8,
    parameter logic [OPCODE_WIDTH-1:0] OP_RET   = 4'h9,
    parameter logic [OPCODE_WIDTH-1:0] OP_HALT  = 4'hE,
    parameter logic [OPCODE_WIDTH-1:0] OP_RESET = 4'hF
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [PC_WIDTH-1:0]                pc,
    output logic                               memReqValid,
    input  logic                               memReqReady,
    output logic [PC_WIDTH-1:0]                memAddr,
    input  logic                               memRspValid,
    input  logic [INSTR_WIDTH-1:0]             memRspData,
    input  logic                               stall,
    output logic                               issue,
    output logic [OPCODE_WIDTH-1:0]            opcode,
    output logic [VALUE_WIDTH-1:0]             operand,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               halted,
    output logic                               fault,
    output logic [1:0]                         faultCode,
    input  logic                               restart
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]              state;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [VALUE_WIDTH-1:0]  operand_q;
    logic [DEPTH_W-1:0]      depth_q;
    logic [1:0]              fault_code_q;
    logic                    overflow;
    logic                    underflow;
    logic                    stop_halt;
    logic                    go;

    // Decisions are taken on the latched word, so they are stable across stall cycles.
    assign overflow  = (opcode_q == OP_CALL) && (depth_q == DEPTH_FULL);
    assign underflow = (opcode_q == OP_RET) && (depth_q == '0);
    assign stop_halt = (opcode_q == OP_HALT);
    assign go        = (state == S_ISSUE) && !stall && !overflow && !underflow && !stop_halt;

    assign memReqValid = (state == S_FETCH);
    assign memAddr     = memReqValid ? pc : '0;
    assign issue       = go;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign depth       = depth_q;
    assign halted      = (state == S_HALT);
    assign fault       = (state == S_FAULT);
    assign faultCode   = fault_code_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            opcode_q     <= '0;
            operand_q    <= '0;
            depth_q      <= '0;
            fault_code_q <= 2'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (memReqReady) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (memRspValid) begin
                        opcode_q  <= memRspData[INSTR_WIDTH-1 -: OPCODE_WIDTH];
                        operand_q <= memRspData[VALUE_WIDTH-1:0];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        if (overflow) begin
                            state        <= S_FAULT;
                            fault_code_q <= 2'd1;
                        end else if (underflow) begin
                            state        <= S_FAULT;
                            fault_code_q <= 2'd2;
                        end else if (stop_halt) begin
                            state <= S_HALT;
                        end else begin
                            state <= S_FETCH;
                            if (opcode_q == OP_CALL)
                                depth_q <= depth_q + DEPTH_W'(1);
                            else if (opcode_q == OP_RET)
                                depth_q <= depth_q - DEPTH_W'(1);
                            else if (opcode_q == OP_RESET)
                                depth_q <= '0;
                        end
                    end
                end
                S_HALT, S_FAULT: begin
                    // Stopped states ignore memory entirely; only restart leaves them.
                    if (restart) begin
                        state        <= S_IDLE;
                        depth_q      <= '0;
                        fault_code_q <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model of depth/halt/fault behaviour.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic        memReqValid;
    logic        memReqReady;
    logic [7:0]  memAddr;
    logic        memRspValid;
    logic [15:0] memRspData;
    logic        stall;
    logic        issue;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic [4:0]  depth;
    logic        halted;
    logic        fault;
    logic [1:0]  faultCode;
    logic        restart;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer dut (
        .clock(clock), .reset(reset), .pc(pc),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memAddr(memAddr),
        .memRspValid(memRspValid), .memRspData(memRspData), .stall(stall),
        .issue(issue), .opcode(opcode), .operand(operand), .depth(depth),
        .halted(halted), .fault(fault), .faultCode(faultCode), .restart(restart)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ready, rspv;
        logic [15:0] data;
        logic        stl, rst_req;
        logic [7:0]  pcv;
        logic        e_req, e_issue;
        logic [3:0]  e_opc;
        logic [11:0] e_opr;
        logic [4:0]  e_depth;
        logic        e_halt, e_fault;
        logic [1:0]  e_code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ready, input logic rspv, input logic [15:0] data,
                                input logic stl, input logic rst_req, input logic [7:0] pcv,
                                input logic e_req, input logic e_issue, input logic [3:0] e_opc,
                                input logic [11:0] e_opr, input logic [4:0] e_depth,
                                input logic e_halt, input logic e_fault, input logic [1:0] e_code);
        vec_t v;
        v.ready = ready; v.rspv = rspv; v.data = data; v.stl = stl; v.rst_req = rst_req;
        v.pcv = pcv; v.e_req = e_req; v.e_issue = e_issue; v.e_opc = e_opc; v.e_opr = e_opr;
        v.e_depth = e_depth; v.e_halt = e_halt; v.e_fault = e_fault; v.e_code = e_code;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Runs one instruction from FETCH: handshake, response next cycle, ISSUE with no stall.
    task automatic do_instr(input logic [15:0] w, output logic iss);
        int n;
        n = 0;
        memReqReady = 1'b1; memRspValid = 1'b0; stall = 1'b0; restart = 1'b0;
        #1;
        while (!memReqValid && n < 10) begin
            step(); #1; n++;
        end
        chk("instr_req_seen", 32'(memReqValid), 32'd1);
        step();
        memReqReady = 1'b0; memRspValid = 1'b1; memRspData = w;
        step();
        memRspValid = 1'b0;
        #1;
        iss = issue;
        step();
    endtask

    // Outcome of an instruction at ISSUE: 0 issue, 1 overflow, 2 underflow, 3 halt.
    function automatic int kind(input logic [15:0] w, input int d);
        if (w[15:12] == 4'h8 && d == 16) return 1;
        if (w[15:12] == 4'h9 && d == 0) return 2;
        if (w[15:12] == 4'hE) return 3;
        return 0;
    endfunction

    function automatic logic [15:0] gen_word();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 15);
        if (r < 5) op = 4'h8;
        else if (r < 8) op = 4'h9;
        else if (r == 8) op = 4'hE;
        else if (r == 9) op = 4'hF;
        else op = 4'($urandom_range(0, 7));
        return {op, 12'($urandom_range(0, 4095))};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic iss;
        vec_t v;
        int m_depth, m_pc, m_code, delay, k, resolved;
        bit m_halt, m_fault, pending, outstanding, deliver, stopped, exp_iss;
        logic [15:0] exp_word;

        reset = 1'b1; pc = 8'h00; memReqReady = 1'b0; memRspValid = 1'b0;
        memRspData = 16'h0000; stall = 1'b0; restart = 1'b0;
        step(); step();
        #1;
        chk("rst_reqvalid", 32'(memReqValid), 32'd0);
        chk("rst_addr", 32'(memAddr), 32'd0);
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_stop", 32'({halted, fault, faultCode}), 32'd0);
        step();

        // Cycle-by-cycle vectors starting in the first cycle out of reset.
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 8'h3C, 0, 0, 4'h0, 12'h000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'hEEEE, 0, 0, 8'h3C, 1, 0, 4'h0, 12'h000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h1005, 0, 0, 8'h3C, 0, 0, 4'h0, 12'h000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h3C, 0, 1, 4'h1, 12'h005, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h3D, 1, 0, 4'h1, 12'h005, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h3D, 1, 0, 4'h1, 12'h005, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h3D, 0, 0, 4'h1, 12'h005, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h8123, 0, 0, 8'h3D, 0, 0, 4'h1, 12'h005, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h3D, 0, 0, 4'h8, 12'h123, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h3D, 0, 1, 4'h8, 12'h123, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h3E, 1, 0, 4'h8, 12'h123, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h9000, 0, 0, 8'h3E, 0, 0, 4'h8, 12'h123, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h3E, 0, 1, 4'h9, 12'h000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h3F, 1, 0, 4'h9, 12'h000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h9001, 0, 0, 8'h3F, 0, 0, 4'h9, 12'h000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h3F, 0, 0, 4'h9, 12'h001, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h1111, 0, 0, 8'h3F, 0, 0, 4'h9, 12'h001, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 8'h3F, 0, 0, 4'h9, 12'h001, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h3F, 0, 0, 4'h9, 12'h001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h3F, 1, 0, 4'h9, 12'h001, 0, 0, 0, 0));

        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            memReqReady = v.ready; memRspValid = v.rspv; memRspData = v.data;
            stall = v.stl; restart = v.rst_req; pc = v.pcv;
            #1;
            chk($sformatf("row%0d_reqvalid", i), 32'(memReqValid), 32'(v.e_req));
            if (v.e_req) chk($sformatf("row%0d_addr", i), 32'(memAddr), 32'(v.pcv));
            chk($sformatf("row%0d_issue", i), 32'(issue), 32'(v.e_issue));
            chk($sformatf("row%0d_opcode", i), 32'(opcode), 32'(v.e_opc));
            chk($sformatf("row%0d_operand", i), 32'(operand), 32'(v.e_opr));
            chk($sformatf("row%0d_depth", i), 32'(depth), 32'(v.e_depth));
            chk($sformatf("row%0d_halted", i), 32'(halted), 32'(v.e_halt));
            chk($sformatf("row%0d_fault", i), 32'(fault), 32'(v.e_fault));
            chk($sformatf("row%0d_faultcode", i), 32'(faultCode), 32'(v.e_code));
            step();
        end

        // Fill the return stack exactly, then one CALL too many.
        for (int i = 0; i < 16; i++) begin
            do_instr(16'h8000 | 16'(i), iss);
            chk($sformatf("call%0d_issue", i), 32'(iss), 32'd1);
        end
        #1;
        chk("full_depth", 32'(depth), 32'd16);
        do_instr(16'h8ABC, iss);
        chk("ovf_issue", 32'(iss), 32'd0);
        #1;
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_code", 32'(faultCode), 32'd1);
        chk("ovf_depth", 32'(depth), 32'd16);
        restart = 1'b1;
        step();
        restart = 1'b0;
        #1;
        chk("restart_clear", 32'({fault, halted, faultCode}), 32'd0);
        chk("restart_depth", 32'(depth), 32'd0);
        chk("restart_idle_req", 32'(memReqValid), 32'd0);

        // HALT is sticky and blocks fetching; reset and restart together.
        do_instr(16'hE000, iss);
        chk("halt_issue", 32'(iss), 32'd0);
        for (int i = 0; i < 3; i++) begin
            memReqReady = 1'b1; memRspValid = 1'b1; memRspData = 16'h1234;
            #1;
            chk($sformatf("halt%0d_halted", i), 32'(halted), 32'd1);
            chk($sformatf("halt%0d_reqvalid", i), 32'(memReqValid), 32'd0);
            chk($sformatf("halt%0d_issue", i), 32'(issue), 32'd0);
            step();
        end
        memRspValid = 1'b0;
        restart = 1'b1; reset = 1'b1;
        #1;
        chk("rr_halted", 32'(halted), 32'd0);
        step();
        reset = 1'b0; restart = 1'b0;
        #1;
        chk("rr_idle_req", 32'(memReqValid), 32'd0);
        step();
        #1;
        chk("rr_fetch_req", 32'(memReqValid), 32'd1);

        // Reset while a response is outstanding: late response must be dropped.
        do_instr(16'h8001, iss);
        chk("pre_call_issue", 32'(iss), 32'd1);
        memReqReady = 1'b1;
        step();
        memReqReady = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("wait_rst_depth", 32'(depth), 32'd0);
        step();
        reset = 1'b0; memRspValid = 1'b1; memRspData = 16'h8ABC;
        #1;
        chk("drop_opcode", 32'(opcode), 32'd0);
        chk("drop_idle_req", 32'(memReqValid), 32'd0);
        step();
        #1;
        chk("drop_fetch_req", 32'(memReqValid), 32'd1);
        chk("drop_opcode2", 32'(opcode), 32'd0);
        step();
        memRspValid = 1'b0;
        do_instr(16'h2077, iss);
        chk("fresh_issue", 32'(iss), 32'd1);
        chk("fresh_word", 32'({opcode, operand}), 32'h2077);
        chk("fresh_depth", 32'(depth), 32'd0);

        // Randomized run against the transaction-level model.
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_depth = 0; m_pc = 0; m_code = 0; m_halt = 0; m_fault = 0;
        pending = 0; outstanding = 0; delay = 0; resolved = 0; exp_word = 16'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            deliver = 0;
            memReqReady = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 2) == 0);
            restart = ($urandom_range(0, 3) == 0);
            pc = 8'(m_pc);
            if (pending) begin
                if (delay == 0) begin
                    memRspValid = 1'b1; memRspData = gen_word(); deliver = 1;
                end else begin
                    memRspValid = 1'b0; delay--;
                end
            end else begin
                memRspValid = 1'($urandom_range(0, 1));
                memRspData = 16'($urandom);
            end
            #1;
            k = outstanding ? kind(exp_word, m_depth) : -1;
            exp_iss = outstanding && !stall && (k == 0);
            chk("rnd_issue", 32'(issue), 32'(exp_iss));
            if (exp_iss) chk("rnd_word", 32'({opcode, operand}), 32'(exp_word));
            chk("rnd_depth", 32'(depth), 32'(m_depth));
            chk("rnd_halted", 32'(halted), 32'(m_halt));
            chk("rnd_fault", 32'(fault), 32'(m_fault));
            chk("rnd_faultcode", 32'(faultCode), 32'(m_code));
            if (memReqValid) chk("rnd_addr", 32'(memAddr), 32'(pc));
            if (pending || outstanding || m_halt || m_fault)
                chk("rnd_reqvalid", 32'(memReqValid), 32'd0);

            stopped = m_halt || m_fault;
            if (outstanding && !stall) begin
                outstanding = 0;
                resolved++;
                if (k == 1) begin m_fault = 1; m_code = 1; end
                else if (k == 2) begin m_fault = 1; m_code = 2; end
                else if (k == 3) m_halt = 1;
                else begin
                    if (exp_word[15:12] == 4'h8) m_depth++;
                    else if (exp_word[15:12] == 4'h9) m_depth--;
                    else if (exp_word[15:12] == 4'hF) m_depth = 0;
                    m_pc = (m_pc + 1) % 256;
                end
            end
            if (stopped && restart) begin
                m_halt = 0; m_fault = 0; m_code = 0; m_depth = 0;
            end
            if (memReqValid && memReqReady && !pending) begin
                pending = 1; delay = $urandom_range(0, 2);
            end
            if (deliver) begin
                pending = 0; outstanding = 1; exp_word = memRspData;
            end
            step();
        end
        chk("rnd_progress", 32'(resolved > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
